// File: rtl/note_controller_pkg.sv
// Shared definitions for the note controller and the oscillator it drives:
// waveform encoding and the C4..C5 period table in clk cycles at 10 MHz.
package note_controller_pkg;

  typedef enum logic [1:0] {
    WAVE_SAW     = 2'd0,
    WAVE_TRI     = 2'd1,
    WAVE_PULSE25 = 2'd2,
    WAVE_SQUARE  = 2'd3
  } wave_mode_t;

  localparam int NUM_NOTES = 13;

  localparam logic [15:0] PERIOD_C4  = 16'd38224;
  localparam logic [15:0] PERIOD_CS4 = 16'd36078;
  localparam logic [15:0] PERIOD_D4  = 16'd34053;
  localparam logic [15:0] PERIOD_DS4 = 16'd32142;
  localparam logic [15:0] PERIOD_E4  = 16'd30338;
  localparam logic [15:0] PERIOD_F4  = 16'd28635;
  localparam logic [15:0] PERIOD_FS4 = 16'd27028;
  localparam logic [15:0] PERIOD_G4  = 16'd25511;
  localparam logic [15:0] PERIOD_GS4 = 16'd24079;
  localparam logic [15:0] PERIOD_A4  = 16'd22728;
  localparam logic [15:0] PERIOD_AS4 = 16'd21452;
  localparam logic [15:0] PERIOD_B4  = 16'd20248;
  localparam logic [15:0] PERIOD_C5  = 16'd19112;

  function automatic wave_mode_t next_wave(input wave_mode_t cur);
    wave_mode_t nxt;
    case (cur)
      WAVE_SAW:     nxt = WAVE_TRI;
      WAVE_TRI:     nxt = WAVE_PULSE25;
      WAVE_PULSE25: nxt = WAVE_SQUARE;
      WAVE_SQUARE:  nxt = WAVE_SAW;
      default:      nxt = WAVE_SAW;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/note_controller_period_lut.sv
// Note index to oscillator period; indices past C5 map to 0 so the
// oscillator stays silent on a corrupted index.
module note_period_lut
  import note_controller_pkg::*;
(
  input  logic [3:0]  idx,
  output logic [15:0] period
);

  // Table lookup
  always_comb begin
    period = 16'd0;
    case (idx)
      4'd0:    period = PERIOD_C4;
      4'd1:    period = PERIOD_CS4;
      4'd2:    period = PERIOD_D4;
      4'd3:    period = PERIOD_DS4;
      4'd4:    period = PERIOD_E4;
      4'd5:    period = PERIOD_F4;
      4'd6:    period = PERIOD_FS4;
      4'd7:    period = PERIOD_G4;
      4'd8:    period = PERIOD_GS4;
      4'd9:    period = PERIOD_A4;
      4'd10:   period = PERIOD_AS4;
      4'd11:   period = PERIOD_B4;
      4'd12:   period = PERIOD_C5;
      default: period = 16'd0;
    endcase
  end

endmodule

// File: rtl/note_controller.sv
// Button front end for a one-voice synth: synchronize and debounce the raw
// buttons, then derive note selection, waveform, octave and period.
module note_controller
  import note_controller_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [12:0] NOTES,
  input  logic        MODE,
  input  logic        OCTAVE,
  output logic [3:0]  note_idx,
  output logic        note_active,
  output logic [1:0]  wave_mode,
  output logic        octave_up,
  output logic [15:0] period,
  output logic        note_load
);

  localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

  logic [14:0] sync_r [SYNC_STAGES];
  logic [14:0] sync_s, sync_prev_r, clean_r, clean_prev_r, rise_s;
  logic [15:0] db_cnt_r;
  logic [12:0] notes_s, note_rise_s;
  logic [3:0]  hi_rise_s, lo_held_s, idx_n_s, note_idx_r;
  logic        active_n_s, oct_n_s, load_n_s, note_active_r, octave_up_r, note_load_r;
  logic [15:0] lut_s, period_n_s, period_r;
  wave_mode_t  wave_n_s, wave_mode_r;

  // Input synchronizer chain for {OCTAVE, MODE, NOTES}
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= 15'd0;
    end else begin
      sync_r[0] <= {OCTAVE, MODE, NOTES};
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Shared debounce: any change restarts the window; once stable the counter saturates
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      sync_prev_r  <= 15'd0;
      db_cnt_r     <= 16'd0;
      clean_r      <= 15'd0;
      clean_prev_r <= 15'd0;
    end else begin
      sync_prev_r  <= sync_s;
      clean_prev_r <= clean_r;
      if (sync_s != sync_prev_r) begin
        db_cnt_r <= 16'd0;
      end else if (db_cnt_r == DB_LAST) begin
        clean_r <= sync_s;
      end else begin
        db_cnt_r <= db_cnt_r + 16'd1;
      end
    end
  end

  assign rise_s      = clean_r & ~clean_prev_r;
  assign notes_s     = clean_r[12:0];
  assign note_rise_s = rise_s[12:0];

  // Highest rising note and lowest held note
  always_comb begin
    hi_rise_s = 4'd0;
    lo_held_s = 4'd0;
    for (int i = 0; i < NUM_NOTES; i++)
      hi_rise_s = note_rise_s[i] ? 4'(i) : hi_rise_s;
    for (int i = NUM_NOTES - 1; i >= 0; i--)
      lo_held_s = notes_s[i] ? 4'(i) : lo_held_s;
  end

  note_period_lut u_lut (
    .idx    (idx_n_s),
    .period (lut_s)
  );

  // Next output state from the clean-register edges
  always_comb begin
    idx_n_s    = note_idx_r;
    active_n_s = note_active_r;
    if (|note_rise_s) begin
      idx_n_s    = hi_rise_s;
      active_n_s = 1'b1;
    end else if (note_active_r && notes_s[note_idx_r]) begin
      idx_n_s    = note_idx_r;
      active_n_s = 1'b1;
    end else if (|notes_s) begin
      idx_n_s    = lo_held_s;
      active_n_s = 1'b1;
    end else begin
      idx_n_s    = note_idx_r;
      active_n_s = 1'b0;
    end
    oct_n_s  = octave_up_r ^ rise_s[14];
    wave_n_s = rise_s[13] ? next_wave(wave_mode_r) : wave_mode_r;
    // Oscillator restarts only on a pitch change, never on a waveform change
    load_n_s = active_n_s & (~note_active_r | (idx_n_s != note_idx_r) |
                             (oct_n_s != octave_up_r));
    if (!active_n_s) begin
      period_n_s = 16'd0;
    end else if (oct_n_s) begin
      period_n_s = {1'b0, lut_s[15:1]};
    end else begin
      period_n_s = lut_s;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      note_idx_r    <= 4'd0;
      note_active_r <= 1'b0;
      wave_mode_r   <= WAVE_SAW;
      octave_up_r   <= 1'b0;
      period_r      <= 16'd0;
      note_load_r   <= 1'b0;
    end else begin
      note_idx_r    <= idx_n_s;
      note_active_r <= active_n_s;
      wave_mode_r   <= wave_n_s;
      octave_up_r   <= oct_n_s;
      period_r      <= period_n_s;
      note_load_r   <= load_n_s;
    end
  end

  assign note_idx    = note_idx_r;
  assign note_active = note_active_r;
  assign wave_mode   = wave_mode_r;
  assign octave_up   = octave_up_r;
  assign period      = period_r;
  assign note_load   = note_load_r;

endmodule

// File: tb/tb_note_controller.sv
// Directed bench for note_controller: each step queues its expected outputs,
// then a fixed settle window pops and compares them and counts note_load pulses.
module tb_note_controller;

  logic        tb_clk = 1'b0;
  logic        RST;
  logic [12:0] NOTES;
  logic        MODE, OCTAVE;
  logic [3:0]  note_idx;
  logic        note_active, octave_up, note_load;
  logic [1:0]  wave_mode;
  logic [15:0] period;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [3:0]  idx;
    logic        active;
    logic [1:0]  wave;
    logic        oct;
    logic [15:0] per;
    int          loads;
  } exp_t;

  exp_t sb[$];

  note_controller #(.SYNC_STAGES(2), .DB_CYCLES(16)) dut (
    .clk         (tb_clk),
    .RST         (RST),
    .NOTES       (NOTES),
    .MODE        (MODE),
    .OCTAVE      (OCTAVE),
    .note_idx    (note_idx),
    .note_active (note_active),
    .wave_mode   (wave_mode),
    .octave_up   (octave_up),
    .period      (period),
    .note_load   (note_load)
  );

  always #50 tb_clk = ~tb_clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic [3:0] idx, input logic act,
                      input logic [1:0] wave, input logic oct, input logic [15:0] per,
                      input int loads);
    exp_t e;
    e.tag = tag; e.idx = idx; e.active = act; e.wave = wave;
    e.oct = oct; e.per = per; e.loads = loads;
    sb.push_back(e);
  endtask

  task automatic window(input int cycles);
    exp_t e;
    int loads;
    loads = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge tb_clk);
      if (note_load === 1'b1) loads++;
    end
    if (cycles == 0) loads = (note_load === 1'b1) ? 1 : 0;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".note_idx"},    32'(note_idx),    32'(e.idx));
      chk({e.tag, ".note_active"}, 32'(note_active), 32'(e.active));
      chk({e.tag, ".wave_mode"},   32'(wave_mode),   32'(e.wave));
      chk({e.tag, ".octave_up"},   32'(octave_up),   32'(e.oct));
      chk({e.tag, ".period"},      32'(period),      32'(e.per));
      chk({e.tag, ".load_pulses"}, 32'(loads),       32'(e.loads));
    end
  endtask

  localparam int W = 40;

  initial begin
    RST = 1'b1; NOTES = 13'd0; MODE = 1'b0; OCTAVE = 1'b0;
    repeat (3) @(negedge tb_clk);
    push("reset", 4'd0, 1'b0, 2'd0, 1'b0, 16'd0, 0);
    window(0);
    RST = 1'b0;

    NOTES = 13'h0001; push("c4_press", 4'd0, 1'b1, 2'd0, 1'b0, 16'd38224, 1); window(W);
    NOTES = 13'h0000; push("c4_release", 4'd0, 1'b0, 2'd0, 1'b0, 16'd0, 0); window(W);

    NOTES = 13'h0200; push("a4_press", 4'd9, 1'b1, 2'd0, 1'b0, 16'd22728, 1); window(W);
    NOTES = 13'h1200; push("c5_over_a4", 4'd12, 1'b1, 2'd0, 1'b0, 16'd19112, 1); window(W);
    NOTES = 13'h0200; push("c5_release", 4'd9, 1'b1, 2'd0, 1'b0, 16'd22728, 1); window(W);
    NOTES = 13'h0000; push("all_release", 4'd9, 1'b0, 2'd0, 1'b0, 16'd0, 0); window(W);

    for (int p = 1; p <= 4; p++) begin
      MODE = 1'b1;
      push($sformatf("mode_press%0d", p), 4'd9, 1'b0, 2'(p % 4), 1'b0, 16'd0, 0);
      window(W);
      MODE = 1'b0;
      push($sformatf("mode_release%0d", p), 4'd9, 1'b0, 2'(p % 4), 1'b0, 16'd0, 0);
      window(W);
    end

    NOTES = 13'h1000; push("c5_press", 4'd12, 1'b1, 2'd0, 1'b0, 16'd19112, 1); window(W);
    OCTAVE = 1'b1; push("octave_up", 4'd12, 1'b1, 2'd0, 1'b1, 16'd9556, 1); window(W);
    OCTAVE = 1'b0; push("octave_release", 4'd12, 1'b1, 2'd0, 1'b1, 16'd9556, 0); window(W);

    NOTES = 13'h1001;
    repeat (8) @(negedge tb_clk);
    NOTES = 13'h1000;
    push("glitch", 4'd12, 1'b1, 2'd0, 1'b1, 16'd9556, 0); window(W);

    NOTES = 13'h1020; MODE = 1'b1; OCTAVE = 1'b1;
    push("simultaneous", 4'd5, 1'b1, 2'd1, 1'b0, 16'd28635, 1); window(W);
    NOTES = 13'h1000; MODE = 1'b0; OCTAVE = 1'b0;
    push("f4_release_fallback", 4'd12, 1'b1, 2'd1, 1'b0, 16'd19112, 1); window(W);
    NOTES = 13'h0000; push("c5_release_idle", 4'd12, 1'b0, 2'd1, 1'b0, 16'd0, 0); window(W);

    NOTES = 13'h0001; push("c4_again", 4'd0, 1'b1, 2'd1, 1'b0, 16'd38224, 1); window(W);
    #20 RST = 1'b1;
    #1 push("reset_mid_note", 4'd0, 1'b0, 2'd0, 1'b0, 16'd0, 0); window(0);
    repeat (3) @(negedge tb_clk);
    RST = 1'b0;
    push("reselect_after_reset", 4'd0, 1'b1, 2'd0, 1'b0, 16'd38224, 1); window(W);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/note_controller.md
NOTE_CONTROLLER -- requirements
Module: note_controller

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth (2..4).
REQ-002 SHALL have parameter DB_CYCLES, default 16, debounce stability window in clk cycles (2..65535).
REQ-003 SHALL have port clk  input  1  system clock, 10 MHz; one clock domain only.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port NOTES  input  13  raw note buttons; bit 0 = C4 ... bit 12 = C5.
REQ-006 SHALL have port MODE  input  1  raw waveform-mode button.
REQ-007 SHALL have port OCTAVE  input  1  raw octave-toggle button.
REQ-008 SHALL have port note_idx  output  4  selected note index 0..12.
REQ-009 SHALL have port note_active  output  1  a note is selected.
REQ-010 SHALL have port wave_mode  output  2  waveform select for the oscillator.
REQ-011 SHALL have port octave_up  output  1  octave state.
REQ-012 SHALL have port period  output  16  oscillator period in clk cycles; 0 when inactive.
REQ-013 SHALL have port note_load  output  1  one-cycle strobe: oscillator reloads period and resets phase.

Function
REQ-014 SHALL pass the 15-bit vector {OCTAVE, MODE, NOTES} through SYNC_STAGES flops.
REQ-015 SHALL run one shared debounce counter that clears whenever the synchronized vector differs from the previous cycle.
REQ-016 SHALL copy the synchronized vector into the clean register when the counter reaches DB_CYCLES-1 with no change, then hold the counter saturated.
REQ-017 SHALL detect rising edges of clean bits by comparison with the previous clean value.
REQ-018 SHALL advance wave_mode on each MODE rising edge: SAW(0) -> TRI(1) -> PULSE25(2) -> SQUARE(3) -> SAW; 3 wraps to 0.
REQ-019 SHALL toggle octave_up on each OCTAVE rising edge.
REQ-020 SHALL select notes with last-note priority: a note rising edge selects that note; if several rise in one cycle, the highest index wins.
REQ-021 SHALL keep the current selection with no rising edge while its clean bit is held.
REQ-022 SHALL, when the selected note is released and others are held, select the lowest held index in the same cycle.
REQ-023 SHALL, when no note is held, drive note_active=0 and period=0; note_idx SHALL keep its last value.
REQ-024 SHALL form period from a 13-entry table (C4..C5): 38224, 36078, 34053, 32142, 30338, 28635, 27028, 25511, 24079, 22728, 21452, 20248, 19112.
REQ-025 SHALL right-shift the table value by 1 (truncating) when octave_up=1.
REQ-026 SHALL register all outputs; they update 1 cycle after the clean-register update.
REQ-027 SHALL pulse note_load for exactly 1 cycle, concurrent with the output update, when note_active rises, or when note_idx or octave_up changes while active.
REQ-028 SHALL give simultaneous MODE, OCTAVE and note edges in one cycle independent, same-cycle effect.
REQ-029 SHALL make a wave_mode-only change not assert note_load.

Reset
REQ-030 SHALL, while RST=1, force sync flops, clean register and counter to 0, and outputs to note_idx=0, note_active=0, wave_mode=SAW, octave_up=0, period=0, note_load=0.
REQ-031 SHALL let reset mid-debounce or mid-note discard pending input; after release, buttons already held produce rising edges once debounced.

Structure
REQ-032 SHALL place the wave_mode encoding and the 13 period constants in a shared package used by the oscillator.
REQ-033 SHALL implement the table as sub-module note_period_lut (combinational, index in, 16-bit period out; out-of-range index gives 0).

Verification
REQ-034 SHALL cover: NOTES bit 0 held -> after 2+16+1 cycles note_active=1, period=38224, one note_load pulse.
REQ-035 SHALL cover: bit 9 held, then bit 12 pressed -> note_idx=12, period=19112, note_load; release bit 12 -> note_idx=9, period=22728, note_load.
REQ-036 SHALL cover: MODE pulsed 3 times, each press and release stable >16 cycles -> wave_mode=SQUARE; a 4th press gives SAW; no note_load.
REQ-037 SHALL cover: OCTAVE pressed with bit 12 held -> period=9556, note_load pulse.
REQ-038 SHALL cover: a bit-0 glitch shorter than 16 cycles -> no output change.
REQ-039 SHALL cover: RST asserted mid-note -> outputs immediately return to reset values; with bit 0 still held, the note reselects after debounce.
